counter_timer_multi: RTL and testbench

Parametrised multi-channel counter/timer for the Caravel housekeeping bus. It provides CHANNELS independent WIDTH-bit up/down counters, each with a reload value, oneshot or continuous mode, a sticky interrupt-pending flag, and an optional external capture register. Register access is through a channel-indexed word interface that a thin Wishbone adapter drives, and all channel interrupts are merged onto a single irq line.

---
 rtl/counter_timer_pkg.sv | 20 ++
 rtl/counter_timer_chan.sv | 130 +++++++++++++
 rtl/counter_timer_multi.sv | 70 +++++++
 tb/tb_counter_timer_multi.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_timer_pkg.sv
// Shared definitions for the multi-channel counter/timer: cfg bit positions,
// cfg field type and the channel-select width helper.
package counter_timer_pkg;

  localparam int CFG_ENABLE    = 0;
  localparam int CFG_ONESHOT   = 1;
  localparam int CFG_UPDOWN    = 2;
  localparam int CFG_IRQ_ENA   = 3;
  localparam int CFG_CAP_ENA   = 4;
  localparam int CFG_PEND      = 5;
  localparam int CFG_CAP_VALID = 6;

  typedef logic [7:0] cfg_t;

  // A single channel still needs a 1-bit select so out-of-range values exist.
  function automatic int ch_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/counter_timer_chan.sv
// One counter/timer channel: up/down counter, reload, cfg, sticky pend and,
// when COUNTER_TIMER_CAPTURE_EN is defined, a synchronised capture register.
module counter_timer_chan
  import counter_timer_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int NB    = WIDTH / 8
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             cfg_we,
  input  logic [NB-1:0]    val_we,
  input  logic [NB-1:0]    dat_we,
  input  logic [WIDTH-1:0] di,
  input  logic             capture,
  output cfg_t             cfg_do,
  output logic [WIDTH-1:0] val_do,
  output logic [WIDTH-1:0] dat_do,
  output logic [WIDTH-1:0] cap_do,
  output logic             stop,
  output logic             pend
);

  logic             enable, oneshot, updown, irq_ena, en_q, stop_q;
  logic [WIDTH-1:0] cur, reload, term, start_v, cur_nxt;
  logic             pend_set, pend_clr;

  assign term     = updown ? reload : '0;
  assign start_v  = updown ? '0 : reload;
  assign cur_nxt  = updown ? cur + 1'b1 : cur - 1'b1;
  assign pend_set = stop & ~stop_q & irq_ena;
  assign pend_clr = cfg_we & di[CFG_PEND];

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      enable  <= 1'b0;
      oneshot <= 1'b0;
      updown  <= 1'b0;
      irq_ena <= 1'b0;
    end else if (cfg_we) begin
      enable  <= di[CFG_ENABLE];
      oneshot <= di[CFG_ONESHOT];
      updown  <= di[CFG_UPDOWN];
      irq_ena <= di[CFG_IRQ_ENA];
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) reload <= '0;
    else
      for (int b = 0; b < NB; b++)
        if (val_we[b]) reload[b*8 +: 8] <= di[b*8 +: 8];
  end

  // A data write pre-empts counting; en_q still tracks enable so a write
  // landing on the start cycle consumes the start.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      cur    <= '0;
      stop   <= 1'b0;
      en_q   <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      en_q   <= enable;
      stop_q <= stop;
      if (|dat_we) begin
        for (int b = 0; b < NB; b++)
          if (dat_we[b]) cur[b*8 +: 8] <= di[b*8 +: 8];
      end else if (enable) begin
        if (!en_q) begin
          cur  <= start_v;
          stop <= 1'b0;
        end else if (cur == term) begin
          if (!oneshot) begin
            cur  <= start_v;
            stop <= 1'b0;
          end
        end else begin
          cur  <= cur_nxt;
          stop <= (cur_nxt == term);
        end
      end
    end
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn)       pend <= 1'b0;
    else if (pend_set) pend <= 1'b1;
    else if (pend_clr) pend <= 1'b0;
  end

  assign val_do = reload;
  assign dat_do = cur;

`ifdef COUNTER_TIMER_CAPTURE_EN
  logic [2:0]       sync;
  logic             cap_ena, cap_valid, cap_hit;
  logic [WIDTH-1:0] cap;

  // Two synchroniser flops plus one for edge detect: load on the 3rd edge.
  assign cap_hit = sync[1] & ~sync[2] & cap_ena;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      sync      <= '0;
      cap_ena   <= 1'b0;
      cap_valid <= 1'b0;
      cap       <= '0;
    end else begin
      sync <= {sync[1:0], capture};
      if (cfg_we) cap_ena <= di[CFG_CAP_ENA];
      if (cap_hit) begin
        cap       <= cur;
        cap_valid <= 1'b1;
      end else if (cfg_we && di[CFG_CAP_VALID]) begin
        cap_valid <= 1'b0;
      end
    end
  end

  assign cap_do = cap;
  assign cfg_do = {1'b0, cap_valid, pend, cap_ena, irq_ena, updown, oneshot, enable};
`else
  logic unused_capture;
  assign unused_capture = capture;
  assign cap_do = '0;
  assign cfg_do = {1'b0, 1'b0, pend, 1'b0, irq_ena, updown, oneshot, enable};
`endif

endmodule

// File: rtl/counter_timer_multi.sv
// CHANNELS-way counter/timer with a channel-indexed register port and merged
// irq. Capture support is built only when COUNTER_TIMER_CAPTURE_EN is defined.
module counter_timer_multi
  import counter_timer_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int CHANNELS = 2,
  localparam int CH_BITS  = ch_bits(CHANNELS),
  localparam int NB       = WIDTH / 8
) (
  input  logic                clkin,
  input  logic                resetn,
  input  logic [CH_BITS-1:0]  ch_sel,
  input  logic                reg_cfg_we,
  input  logic [NB-1:0]       reg_val_we,
  input  logic [NB-1:0]       reg_dat_we,
  input  logic [WIDTH-1:0]    reg_di,
  output logic [7:0]          reg_cfg_do,
  output logic [WIDTH-1:0]    reg_val_do,
  output logic [WIDTH-1:0]    reg_dat_do,
  output logic [WIDTH-1:0]    reg_cap_do,
  input  logic [CHANNELS-1:0] capture_in,
  output logic [CHANNELS-1:0] stop_out,
  output logic [CHANNELS-1:0] irq_pend,
  output logic                irq
);

  cfg_t       [CHANNELS-1:0]            cfg_a;
  logic       [CHANNELS-1:0][WIDTH-1:0] val_a, dat_a, cap_a;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic hit;
    assign hit = (ch_sel == CH_BITS'(i));

    counter_timer_chan #(.WIDTH(WIDTH)) u_chan (
      .clkin   (clkin),
      .resetn  (resetn),
      .cfg_we  (reg_cfg_we & hit),
      .val_we  (reg_val_we & {NB{hit}}),
      .dat_we  (reg_dat_we & {NB{hit}}),
      .di      (reg_di),
      .capture (capture_in[i]),
      .cfg_do  (cfg_a[i]),
      .val_do  (val_a[i]),
      .dat_do  (dat_a[i]),
      .cap_do  (cap_a[i]),
      .stop    (stop_out[i]),
      .pend    (irq_pend[i])
    );
  end

  // Unmapped selects fall through to zero.
  always_comb begin
    reg_cfg_do = '0;
    reg_val_do = '0;
    reg_dat_do = '0;
    reg_cap_do = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch_sel == CH_BITS'(i)) begin
        reg_cfg_do = cfg_a[i];
        reg_val_do = val_a[i];
        reg_dat_do = dat_a[i];
        reg_cap_do = cap_a[i];
      end
    end
  end

  assign irq = |irq_pend;

endmodule

// File: tb/tb_counter_timer_multi.sv
// Self-checking bench for counter_timer_multi: register table, hand corner
// sequences, randomised trials against a closed-form model, 8-bit wrap.
module tb_counter_timer_multi;

`ifdef COUNTER_TIMER_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clkin = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  ch_sel = '0;
  logic        cfg_we = 1'b0;
  logic [3:0]  val_we = '0, dat_we = '0;
  logic [31:0] di = '0;
  logic [7:0]  cfg_do;
  logic [31:0] val_do, dat_do, cap_do;
  logic [4:0]  cap_in = '0, stop_out, irq_pend;
  logic        irq;

  logic       b_sel = 1'b0, b_cfg_we = 1'b0, b_cap_in = 1'b0;
  logic [0:0] b_val_we = '0, b_dat_we = '0, b_stop, b_pend;
  logic [7:0] b_di = '0, b_cfg_do, b_val_do, b_dat_do, b_cap_do;
  logic       b_irq;

  int tests = 0, fails = 0;

  always #5 clkin = ~clkin;

  counter_timer_multi #(.WIDTH(32), .CHANNELS(5)) dut (
    .clkin(clkin), .resetn(resetn), .ch_sel(ch_sel), .reg_cfg_we(cfg_we),
    .reg_val_we(val_we), .reg_dat_we(dat_we), .reg_di(di), .reg_cfg_do(cfg_do),
    .reg_val_do(val_do), .reg_dat_do(dat_do), .reg_cap_do(cap_do),
    .capture_in(cap_in), .stop_out(stop_out), .irq_pend(irq_pend), .irq(irq));

  counter_timer_multi #(.WIDTH(8), .CHANNELS(1)) u8 (
    .clkin(clkin), .resetn(resetn), .ch_sel(b_sel), .reg_cfg_we(b_cfg_we),
    .reg_val_we(b_val_we), .reg_dat_we(b_dat_we), .reg_di(b_di), .reg_cfg_do(b_cfg_do),
    .reg_val_do(b_val_do), .reg_dat_do(b_dat_do), .reg_cap_do(b_cap_do),
    .capture_in(b_cap_in), .stop_out(b_stop), .irq_pend(b_pend), .irq(b_irq));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    @(negedge clkin);
  endtask

  task automatic wr(input int ch, input logic c, input logic [3:0] v, input logic [3:0] d,
                    input logic [31:0] data);
    ch_sel = 3'(ch); cfg_we = c; val_we = v; dat_we = d; di = data;
    step();
    cfg_we = 1'b0; val_we = '0; dat_we = '0;
  endtask

  // Closed-form view: after n counting cycles since start.
  function automatic longint exp_cur(input int n, input longint r, input bit up, input bit one);
    longint m;
    if (one) m = (n > r) ? r : longint'(n);
    else     m = n % (r + 1);
    return up ? m : r - m;
  endfunction

  function automatic bit exp_stop(input longint cur, input longint r, input bit up);
    return (r != 0) && (cur == (up ? r : 0));
  endfunction

  function automatic bit exp_pend(input int n, input longint r, input bit ie);
    return ie && (r != 0) && (n >= r + 1);
  endfunction

  typedef struct {
    logic [2:0]  ch;
    logic        c;
    logic [3:0]  v, d;
    logic [31:0] data;
    logic [7:0]  ecfg;
    logic [31:0] eval, edat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    longint ec;
    tbl[0] = '{3'd0, 1'b0, 4'hF, 4'h0, 32'h12345678, 8'h00, 32'h12345678, 32'h0};
    tbl[1] = '{3'd0, 1'b0, 4'h1, 4'h0, 32'hAAAAAAFF, 8'h00, 32'h123456FF, 32'h0};
    tbl[2] = '{3'd1, 1'b0, 4'hC, 4'h0, 32'hCAFE0000, 8'h00, 32'hCAFE0000, 32'h0};
    tbl[3] = '{3'd0, 1'b0, 4'h0, 4'h0, 32'h0,        8'h00, 32'h123456FF, 32'h0};
    tbl[4] = '{3'd5, 1'b1, 4'hF, 4'hF, 32'hFFFFFFFF, 8'h00, 32'h0,        32'h0};
    tbl[5] = '{3'd1, 1'b0, 4'h0, 4'h0, 32'h0,        8'h00, 32'hCAFE0000, 32'h0};
    tbl[6] = '{3'd2, 1'b0, 4'h0, 4'hF, 32'h00000042, 8'h00, 32'h0,        32'h42};
    tbl[7] = '{3'd2, 1'b1, 4'h0, 4'h0, 32'h000000FE, CAP ? 8'h1E : 8'h0E, 32'h0, 32'h42};
    tbl[8] = '{3'd7, 1'b1, 4'h0, 4'h0, 32'h00000001, 8'h00, 32'h0,        32'h0};
    tbl[9] = '{3'd2, 1'b1, 4'h0, 4'h0, 32'h00000000, 8'h00, 32'h0,        32'h42};

    // Reset state
    repeat (2) step();
    chk("rst_stop", stop_out, 0); chk("rst_pend", irq_pend, 0); chk("rst_irq", irq, 0);
    chk("rst_cfg", cfg_do, 0); chk("rst_val", val_do, 0);
    chk("rst_dat", dat_do, 0); chk("rst_cap", cap_do, 0);
    resetn = 1'b1;
    step();

    // Register access table
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].ch, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].data);
      chk($sformatf("tbl%0d_cfg", i), cfg_do, tbl[i].ecfg);
      chk($sformatf("tbl%0d_val", i), val_do, tbl[i].eval);
      chk($sformatf("tbl%0d_dat", i), dat_do, tbl[i].edat);
    end

    // Ch0: up, continuous, irq, reload 3
    wr(0, 1'b0, 4'hF, 4'h0, 32'd3);
    wr(0, 1'b1, 4'h0, 4'h0, 32'h0D);
    for (int k = 1; k <= 10; k++) begin
      step();
      ec = exp_cur(k - 1, 3, 1, 0);
      chk($sformatf("a_cur%0d", k), dat_do, ec);
      chk($sformatf("a_stop%0d", k), stop_out[0], exp_stop(ec, 3, 1));
      chk($sformatf("a_pend%0d", k), irq_pend[0], exp_pend(k - 1, 3, 1));
      chk($sformatf("a_irq%0d", k), irq, exp_pend(k - 1, 3, 1));
    end
    wr(0, 1'b1, 4'h0, 4'h0, 32'h2D);
    chk("a_clr_pend", irq_pend[0], 0); chk("a_clr_irq", irq, 0); chk("a_clr_cur", dat_do, 2);
    step();
    chk("a12_cur", dat_do, 3); chk("a12_stop", stop_out[0], 1); chk("a12_pend", irq_pend[0], 0);
    wr(0, 1'b1, 4'h0, 4'h0, 32'h2D);
    chk("a_setwins_pend", irq_pend[0], 1); chk("a13_cur", dat_do, 0);

    // Ch1: down, oneshot, no irq, reload 5
    wr(1, 1'b0, 4'hF, 4'h0, 32'd5);
    wr(1, 1'b1, 4'h0, 4'h0, 32'h03);
    for (int k = 1; k <= 10; k++) begin
      step();
      ec = exp_cur(k - 1, 5, 0, 1);
      chk($sformatf("b_cur%0d", k), dat_do, ec);
      chk($sformatf("b_stop%0d", k), stop_out[1], exp_stop(ec, 5, 0));
      chk($sformatf("b_pend%0d", k), irq_pend[1], 0);
    end

    // Ch2: byte writes while counting take priority
    wr(2, 1'b0, 4'hF, 4'h0, 32'h10000);
    wr(2, 1'b1, 4'h0, 4'h0, 32'h05);
    repeat (3) step();
    chk("c_cur", dat_do, 2);
    wr(2, 1'b0, 4'h0, 4'hF, 32'h1234);
    chk("c_wr_all", dat_do, 32'h1234);
    step();
    chk("c_inc", dat_do, 32'h1235);
    wr(2, 1'b0, 4'h0, 4'h1, 32'hFFFFFFAA);
    chk("c_wr_b0", dat_do, 32'h12AA);
    step();
    chk("c_inc2", dat_do, 32'h12AB);

    // Ch3: capture
    wr(3, 1'b0, 4'hF, 4'h0, 32'h10000);
    wr(3, 1'b1, 4'h0, 4'h0, 32'h15);
    repeat (11) step();
    chk("e_cur", dat_do, 10);
    cap_in[3] = 1'b1;
    step(); step();
    chk("e_cap_early", cap_do, 0); chk("e_valid_early", cfg_do[6], 0);
    step();
    chk("e_cap", cap_do, CAP ? 64'd12 : 64'd0);
    chk("e_cfg", cfg_do, CAP ? 8'h55 : 8'h05);
    chk("e_cur13", dat_do, 13);
    cap_in[3] = 1'b0;
    wr(3, 1'b1, 4'h0, 4'h0, 32'h55);
    chk("e_clr_cfg", cfg_do, CAP ? 8'h15 : 8'h05);

    // Asynchronous reset mid-count
    chk("f_pre_irq", irq, 1);
    #1 resetn = 1'b0;
    #1;
    chk("f_stop", stop_out, 0); chk("f_pend", irq_pend, 0); chk("f_irq", irq, 0);
    chk("f_dat", dat_do, 0); chk("f_cfg", cfg_do, 0); chk("f_cap", cap_do, 0);
    @(negedge clkin);
    resetn = 1'b1;
    step();

    // Randomised trials against the closed-form model
    for (int t = 0; t < 30; t++) begin
      int ch, n_cyc;
      longint r;
      bit up, one, ie;
      ch = $urandom_range(0, 4);
      r = $urandom_range(0, 12);
      up = 1'($urandom); one = 1'($urandom); ie = 1'($urandom);
      n_cyc = $urandom_range(5, 40);
      wr(ch, 1'b0, 4'hF, 4'h0, 32'(r));
      wr(ch, 1'b1, 4'h0, 4'h0, {28'h0, ie, up, one, 1'b1});
      for (int k = 1; k <= n_cyc; k++) begin
        step();
        ec = exp_cur(k - 1, r, up, one);
        chk($sformatf("r%0d_cur%0d", t, k), dat_do, ec);
        chk($sformatf("r%0d_stop%0d", t, k), stop_out[ch], exp_stop(ec, r, up));
        chk($sformatf("r%0d_pend%0d", t, k), irq_pend[ch], exp_pend(k - 1, r, ie));
        chk($sformatf("r%0d_irq%0d", t, k), irq, exp_pend(k - 1, r, ie));
      end
      wr(ch, 1'b1, 4'h0, 4'h0, 32'h60);
      wr(ch, 1'b1, 4'h0, 4'h0, 32'h60);
    end

    // 8-bit: down, continuous, reload 0xFF wraps 0 -> 0xFF
    b_val_we = 1'b1; b_di = 8'hFF; step(); b_val_we = 1'b0;
    b_cfg_we = 1'b1; b_di = 8'h01; step(); b_cfg_we = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      step();
      ec = exp_cur(k - 1, 255, 0, 0);
      chk($sformatf("w8_cur%0d", k), b_dat_do, ec);
      chk($sformatf("w8_stop%0d", k), b_stop, exp_stop(ec, 255, 0));
    end
    chk("w8_known", $isunknown({b_dat_do, b_cfg_do, b_val_do, b_cap_do}), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
